// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM states and the ALU / PC / register-destination select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000,
                         OP_J     = 6'b000010,
                         OP_JAL   = 6'b000011,
                         OP_BEQ   = 6'b000100,
                         OP_BNE   = 6'b000101,
                         OP_ADDIU = 6'b001001,
                         OP_SLTI  = 6'b001010,
                         OP_ANDI  = 6'b001100,
                         OP_ORI   = 6'b001101,
                         OP_XORI  = 6'b001110,
                         OP_LW    = 6'b100011,
                         OP_SW    = 6'b101011,
                         OP_HALT  = 6'b111111;

  localparam logic [5:0] F_SLL = 6'b000000,
                         F_JR  = 6'b001000,
                         F_ADD = 6'b100000,
                         F_SUB = 6'b100010,
                         F_AND = 6'b100100,
                         F_OR  = 6'b100101,
                         F_XOR = 6'b100110,
                         F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000,
                         ALU_SUB = 3'b001,
                         ALU_SLL = 3'b010,
                         ALU_OR  = 3'b011,
                         ALU_AND = 3'b100,
                         ALU_SLT = 3'b101,
                         ALU_XOR = 3'b110;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00,
                         PCSRC_BRANCH = 2'b01,
                         PCSRC_REG    = 2'b10,
                         PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00,
                         REGDST_RT = 2'b01,
                         REGDST_RD = 2'b10;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  function automatic logic is_i_alu(input logic [5:0] op);
    return op inside {OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  // R-type functs that produce a register result (jr and unknown functs excluded).
  function automatic logic is_r_alu(input logic [5:0] funct);
    return funct inside {F_SLL, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps (op, funct) to the ALU operation code; shared by the single-cycle and
// multi-cycle control units, so it carries no state.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SUB:   alu_op = ALU_SUB;
          F_SLL:   alu_op = ALU_SLL;
          F_OR:    alu_op = ALU_OR;
          F_AND:   alu_op = ALU_AND;
          F_SLT:   alu_op = ALU_SLT;
          F_XOR:   alu_op = ALU_XOR;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_ANDI:        alu_op = ALU_AND;
      OP_ORI:         alu_op = ALU_OR;
      OP_XORI:        alu_op = ALU_XOR;
      OP_SLTI:        alu_op = ALU_SLT;
      default:        alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: a state register plus
// combinational decode of every datapath enable and select.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ExtSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [2:0] state,
  output logic       halted
);

  state_t     cur_state, next_state;
  logic       halt_q;
  logic [2:0] dec_alu_op;

  logic is_rtype, is_jr, is_sll, is_jump, is_br, is_ls, is_ialu, is_halt;
  logic zero_ext, op_known, halt_now, br_taken;

  alu_decoder u_alu_decoder (
    .op     (op),
    .funct  (funct),
    .alu_op (dec_alu_op)
  );

  assign is_rtype = (op == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == F_JR);
  assign is_sll   = is_rtype && (funct == F_SLL);
  assign is_jump  = (op == OP_J) || (op == OP_JAL);
  assign is_br    = (op == OP_BEQ) || (op == OP_BNE);
  assign is_ls    = (op == OP_LW) || (op == OP_SW);
  assign is_ialu  = is_i_alu(op);
  assign is_halt  = (op == OP_HALT);
  assign zero_ext = op inside {OP_ANDI, OP_ORI, OP_XORI};
  assign op_known = is_rtype || is_ialu || is_ls || is_br || is_jump || is_halt;
  assign br_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

  // Halt is sticky: once seen in ID the FSM parks there until reset, whatever IR holds.
  assign halt_now = halt_q || ((cur_state == S_ID) && is_halt);
  assign halted   = halt_now;
  assign state    = cur_state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cur_state <= S_IF;
      halt_q    <= 1'b0;
    end else begin
      cur_state <= next_state;
      if ((cur_state == S_ID) && is_halt) halt_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = S_IF;
    unique case (cur_state)
      S_IF: next_state = S_ID;
      S_ID: begin
        if (halt_now)                   next_state = S_ID;
        else if (is_jump || is_jr)      next_state = S_IF;
        else if (is_br)                 next_state = S_EXE_BR;
        else if (is_ls)                 next_state = S_EXE_LS;
        else if (is_rtype || is_ialu)   next_state = S_EXE_AL;
        else                            next_state = S_IF;
      end
      S_EXE_LS: next_state = S_MEM;
      S_MEM:    next_state = (op == OP_SW) ? S_IF : S_WB_LD;
      S_WB_LD:  next_state = S_IF;
      S_EXE_BR: next_state = S_IF;
      S_EXE_AL: next_state = S_WB_AL;
      S_WB_AL:  next_state = S_IF;
      default:  next_state = S_IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    RegWre    = 1'b0;
    RegDst    = REGDST_RA;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PCSRC_SEQ;

    // IF decode is independent of op, since IR holds the previous instruction there.
    if (cur_state != S_IF) begin
      ExtSel  = !zero_ext;
      ALUSrcA = is_sll;
      ALUSrcB = is_ialu || is_ls;
      ALUOp   = dec_alu_op;
    end

    unique case (cur_state)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (!halt_now) begin
          if (is_jump) begin
            PCWre = 1'b1;
            PCSrc = PCSRC_JUMP;
            if (op == OP_JAL) begin
              RegWre    = 1'b1;
              RegDst    = REGDST_RA;
              WrRegDSrc = 1'b0;
            end
          end else if (is_jr) begin
            PCWre = 1'b1;
            PCSrc = PCSRC_REG;
          end else if (!op_known) begin
            PCWre = 1'b1;
            PCSrc = PCSRC_SEQ;
          end
        end
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = br_taken ? PCSRC_BRANCH : PCSRC_SEQ;
      end
      S_MEM: begin
        mRD   = (op == OP_LW);
        mWR   = (op == OP_SW);
        PCWre = (op == OP_SW);
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = REGDST_RT;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
      end
      S_WB_AL: begin
        PCWre     = 1'b1;
        RegWre    = (is_rtype && is_r_alu(funct)) || is_ialu;
        RegDst    = is_rtype ? REGDST_RD : REGDST_RT;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
